// File: rtl/regfile_write_sched_if.sv
// Writeback-to-register-file bus for the write scheduler: two requesters in,
// one register-file write port and a read-modify-write read port out.
interface regfile_write_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_byte;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_byte;
  logic              rf_regWrite;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rf_rmw_reg;
  logic [DATA_W-1:0] rf_rmw_data;
  logic              busy;
  logic [CNT_W-1:0]  wr_count;

  modport slave (
    input  alu_valid, alu_reg, alu_data, alu_byte,
    input  mem_valid, mem_reg, mem_data, mem_byte,
    input  rf_rmw_data,
    output alu_ready, mem_ready,
    output rf_regWrite, rf_write_reg, rf_write_data, rf_rmw_reg,
    output busy, wr_count
  );

  modport master (
    output alu_valid, alu_reg, alu_data, alu_byte,
    output mem_valid, mem_reg, mem_data, mem_byte,
    output rf_rmw_data,
    input  alu_ready, mem_ready,
    input  rf_regWrite, rf_write_reg, rf_write_data, rf_rmw_reg,
    input  busy, wr_count
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Round-robin scheduler for the single register-file write port, with
// register-0 drop and low-byte read-modify-write.
module regfile_write_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RMW_READ  = 2'd1,
    RMW_WRITE = 2'd2
  } state_e;

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'({BYTE_W{1'b1}});

  state_e              state_q;
  logic                last_grant_q;
  logic                we_q;
  logic [ADDR_W-1:0]   wreg_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   rmw_reg_q;
  logic [BYTE_W-1:0]   cap_byte_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                grant_alu_d;
  logic                grant_mem_d;
  logic [ADDR_W-1:0]   sel_reg_d;
  logic [DATA_W-1:0]   sel_data_d;
  logic                sel_byte_d;
  logic [DATA_W-1:0]   merge_d;
  logic [CNT_W-1:0]    cnt_d;

  // Grant and request selection: only IDLE accepts; on conflict the requester that did not win last goes.
  always_comb begin
    grant_alu_d = 1'b0;
    grant_mem_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.alu_valid && bus.mem_valid) begin
        grant_alu_d = (last_grant_q == GRANT_MEM);
        grant_mem_d = (last_grant_q == GRANT_ALU);
      end else begin
        grant_alu_d = bus.alu_valid;
        grant_mem_d = bus.mem_valid;
      end
    end else begin
      grant_alu_d = 1'b0;
      grant_mem_d = 1'b0;
    end
    if (grant_mem_d) begin
      sel_reg_d  = bus.mem_reg;
      sel_data_d = bus.mem_data;
      sel_byte_d = bus.mem_byte;
    end else begin
      sel_reg_d  = bus.alu_reg;
      sel_data_d = bus.alu_data;
      sel_byte_d = bus.alu_byte;
    end
    merge_d = (bus.rf_rmw_data & ~BYTE_MASK) | DATA_W'(cap_byte_q);
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Scheduler FSM; the counter advances together with the strobe so it already includes the write on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_MEM;
      we_q         <= 1'b0;
      wreg_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      rmw_reg_q    <= {ADDR_W{1'b0}};
      cap_byte_q   <= {BYTE_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_alu_d || grant_mem_d) begin
            last_grant_q <= grant_mem_d ? GRANT_MEM : GRANT_ALU;
            if (sel_reg_d != {ADDR_W{1'b0}}) begin
              if (sel_byte_d) begin
                state_q    <= RMW_READ;
                rmw_reg_q  <= sel_reg_d;
                cap_byte_q <= sel_data_d[BYTE_W-1:0];
              end else begin
                we_q    <= 1'b1;
                wreg_q  <= sel_reg_d;
                wdata_q <= sel_data_d;
                cnt_q   <= cnt_d;
              end
            end
          end
        end
        RMW_READ: begin
          we_q    <= 1'b1;
          wreg_q  <= rmw_reg_q;
          wdata_q <= merge_d;
          cnt_q   <= cnt_d;
          state_q <= RMW_WRITE;
        end
        RMW_WRITE: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_ready     = grant_alu_d;
  assign bus.mem_ready     = grant_mem_d;
  assign bus.rf_regWrite   = we_q;
  assign bus.rf_write_reg  = wreg_q;
  assign bus.rf_write_data = wdata_q;
  assign bus.rf_rmw_reg    = rmw_reg_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.wr_count      = cnt_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Randomized bench for regfile_write_sched against a cycle-level behavioural
// model, plus directed scenarios pinned with hand-computed values.
module tb_regfile_write_sched;

  logic clk;
  logic reset;

  regfile_write_sched_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
  regfile_write_sched_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2))  sbus ();

  regfile_write_sched #(.DATA_W(32), .ADDR_W(5), .BYTE_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  regfile_write_sched #(.DATA_W(32), .ADDR_W(5), .BYTE_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus));

  logic [31:0] m_rf [32];

  assign bus.rf_rmw_data  = m_rf[bus.rf_rmw_reg];
  assign sbus.rf_rmw_data = m_rf[sbus.rf_rmw_reg];
  assign sbus.alu_valid = bus.alu_valid;
  assign sbus.alu_reg   = bus.alu_reg;
  assign sbus.alu_data  = bus.alu_data;
  assign sbus.alu_byte  = bus.alu_byte;
  assign sbus.mem_valid = bus.mem_valid;
  assign sbus.mem_reg   = bus.mem_reg;
  assign sbus.mem_data  = bus.mem_data;
  assign sbus.mem_byte  = bus.mem_byte;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: remaining busy cycles, round-robin memory, expected outputs.
  int          rmw_left;
  bit          last_mem;
  logic [4:0]  pend_reg;
  logic [7:0]  pend_byte;
  bit          e_we;
  logic [4:0]  e_wreg;
  logic [31:0] e_wdata;
  logic [4:0]  e_rmwreg;
  int          commits;
  bit          g_alu, g_mem;
  bit          alu_pend, mem_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rmw_left = 0;
    last_mem = 1'b1;
    e_we     = 1'b0;
    e_wreg   = 5'd0;
    e_wdata  = 32'd0;
    e_rmwreg = 5'd0;
    commits  = 0;
  endtask

  task automatic model_grant();
    g_alu = 1'b0;
    g_mem = 1'b0;
    if (rmw_left == 0) begin
      if (bus.alu_valid && bus.mem_valid) begin
        g_alu = last_mem;
        g_mem = !last_mem;
      end else begin
        g_alu = bus.alu_valid;
        g_mem = bus.mem_valid;
      end
    end
  endtask

  task automatic check_all();
    int sat16, sat2;
    model_grant();
    sat16 = (commits > 65535) ? 65535 : commits;
    sat2  = (commits > 3) ? 3 : commits;
    chk("alu_ready", bus.alu_ready, g_alu);
    chk("mem_ready", bus.mem_ready, g_mem);
    chk("busy", bus.busy, (rmw_left != 0));
    chk("rf_regWrite", bus.rf_regWrite, e_we);
    chk("wr_count", bus.wr_count, sat16);
    if (e_we) begin
      chk("rf_write_reg", bus.rf_write_reg, e_wreg);
      chk("rf_write_data", bus.rf_write_data, e_wdata);
      chk("sat_write_data", sbus.rf_write_data, e_wdata);
    end
    if (rmw_left == 2) chk("rf_rmw_reg", bus.rf_rmw_reg, e_rmwreg);
    chk("sat_alu_ready", sbus.alu_ready, g_alu);
    chk("sat_regWrite", sbus.rf_regWrite, e_we);
    chk("sat_wr_count", sbus.wr_count, sat2);
  endtask

  // Advance the model across one rising edge; the register file absorbs the current write.
  task automatic model_step();
    bit          n_we;
    logic [4:0]  r;
    logic [31:0] d;
    bit          b;
    if (reset) begin
      model_reset();
      return;
    end
    if (e_we) m_rf[e_wreg] = e_wdata;
    n_we = 1'b0;
    if (rmw_left == 2) begin
      n_we     = 1'b1;
      e_wreg   = pend_reg;
      e_wdata  = {m_rf[pend_reg][31:8], pend_byte};
      rmw_left = 1;
    end else if (rmw_left == 1) begin
      rmw_left = 0;
    end else if (g_alu || g_mem) begin
      last_mem = g_mem;
      r = g_mem ? bus.mem_reg  : bus.alu_reg;
      d = g_mem ? bus.mem_data : bus.alu_data;
      b = g_mem ? bus.mem_byte : bus.alu_byte;
      if (r != 5'd0) begin
        if (b) begin
          rmw_left  = 2;
          pend_reg  = r;
          pend_byte = d[7:0];
          e_rmwreg  = r;
        end else begin
          n_we    = 1'b1;
          e_wreg  = r;
          e_wdata = d;
        end
      end
    end
    e_we = n_we;
    if (n_we) commits++;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_alu(input bit v, input logic [4:0] r, input logic [31:0] d, input bit b);
    bus.alu_valid = v; bus.alu_reg = r; bus.alu_data = d; bus.alu_byte = b;
  endtask

  task automatic set_mem(input bit v, input logic [4:0] r, input logic [31:0] d, input bit b);
    bus.mem_valid = v; bus.mem_reg = r; bus.mem_data = d; bus.mem_byte = b;
  endtask

  initial begin
    set_alu(1'b0, 5'd0, 32'd0, 1'b0);
    set_mem(1'b0, 5'd0, 32'd0, 1'b0);
    reset = 1'b1;
    m_rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) m_rf[i] = $urandom;
    m_rf[5] = 32'h1234_5678;
    model_reset();
    alu_pend = 1'b0;
    mem_pend = 1'b0;

    #1;
    chk("rst_regWrite", bus.rf_regWrite, 32'd0);
    chk("rst_write_reg", bus.rf_write_reg, 32'd0);
    chk("rst_write_data", bus.rf_write_data, 32'd0);
    chk("rst_rmw_reg", bus.rf_rmw_reg, 32'd0);
    chk("rst_wr_count", bus.wr_count, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    cycle();
    reset = 1'b0;

    // Single ALU word write
    set_alu(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    #1 chk("alu_word_ready", bus.alu_ready, 32'd1);
    cycle();
    set_alu(1'b0, 5'd0, 32'd0, 1'b0);
    chk("alu_word_we", bus.rf_regWrite, 32'd1);
    chk("alu_word_reg", bus.rf_write_reg, 32'd3);
    chk("alu_word_data", bus.rf_write_data, 32'hDEAD_BEEF);
    chk("alu_word_cnt", bus.wr_count, 32'd1);
    cycle();
    chk("alu_word_we_off", bus.rf_regWrite, 32'd0);

    // Byte read-modify-write from the memory side, ALU held off meanwhile
    set_mem(1'b1, 5'd5, 32'h0000_00AB, 1'b1);
    cycle();
    set_mem(1'b0, 5'd0, 32'd0, 1'b0);
    set_alu(1'b1, 5'd7, 32'd1, 1'b0);
    chk("rmw_rd_busy", bus.busy, 32'd1);
    chk("rmw_rd_reg", bus.rf_rmw_reg, 32'd5);
    chk("rmw_rd_we", bus.rf_regWrite, 32'd0);
    #1 chk("rmw_rd_alu_ready", bus.alu_ready, 32'd0);
    cycle();
    chk("rmw_wr_we", bus.rf_regWrite, 32'd1);
    chk("rmw_wr_reg", bus.rf_write_reg, 32'd5);
    chk("rmw_wr_data", bus.rf_write_data, 32'h1234_56AB);
    #1 chk("rmw_wr_alu_ready", bus.alu_ready, 32'd0);
    cycle();
    chk("rmw_model_rf5", m_rf[5], 32'h1234_56AB);
    #1 chk("rmw_done_alu_ready", bus.alu_ready, 32'd1);
    cycle();
    set_alu(1'b0, 5'd0, 32'd0, 1'b0);
    cycle();

    // Reset in the middle of a read-modify-write
    set_mem(1'b1, 5'd9, 32'h0000_0055, 1'b1);
    cycle();
    set_mem(1'b0, 5'd0, 32'd0, 1'b0);
    chk("midrst_busy_before", bus.busy, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy", bus.busy, 32'd0);
    chk("midrst_we", bus.rf_regWrite, 32'd0);
    chk("midrst_cnt", bus.wr_count, 32'd0);
    chk("midrst_rmw_reg", bus.rf_rmw_reg, 32'd0);
    cycle();
    reset = 1'b0;
    cycle();
    chk("midrst_no_strobe1", bus.rf_regWrite, 32'd0);
    cycle();
    chk("midrst_no_strobe2", bus.rf_regWrite, 32'd0);

    // Conflict right after reset: ALU first, then alternate
    set_alu(1'b1, 5'd1, 32'h0000_00A1, 1'b0);
    set_mem(1'b1, 5'd2, 32'h0000_00B2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("conf_alu_ready", bus.alu_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("conf_mem_ready", bus.mem_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      cycle();
      chk("conf_we", bus.rf_regWrite, 32'd1);
      chk("conf_reg", bus.rf_write_reg, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("conf_cnt", bus.wr_count, i + 1);
      chk("conf_sat_cnt", sbus.wr_count, (i < 3) ? i + 1 : 3);
    end
    set_alu(1'b0, 5'd0, 32'd0, 1'b0);
    set_mem(1'b0, 5'd0, 32'd0, 1'b0);
    cycle();

    // Register 0 requests are accepted and dropped
    set_alu(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    #1 chk("r0_word_ready", bus.alu_ready, 32'd1);
    cycle();
    set_alu(1'b0, 5'd0, 32'd0, 1'b0);
    chk("r0_word_we", bus.rf_regWrite, 32'd0);
    set_mem(1'b1, 5'd0, 32'h0000_00CC, 1'b1);
    #1 chk("r0_byte_ready", bus.mem_ready, 32'd1);
    cycle();
    set_mem(1'b0, 5'd0, 32'd0, 1'b0);
    chk("r0_byte_we", bus.rf_regWrite, 32'd0);
    chk("r0_byte_busy", bus.busy, 32'd0);
    chk("r0_cnt", bus.wr_count, 32'd4);

    // Fifth write: narrow counter stays saturated
    set_alu(1'b1, 5'd4, 32'h0000_0004, 1'b0);
    cycle();
    set_alu(1'b0, 5'd0, 32'd0, 1'b0);
    chk("sat_fifth", sbus.wr_count, 32'd3);
    chk("cnt_fifth", bus.wr_count, 32'd5);
    cycle();

    // Randomized traffic with held requests and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        set_alu(1'b0, 5'd0, 32'd0, 1'b0);
        set_mem(1'b0, 5'd0, 32'd0, 1'b0);
        alu_pend = 1'b0;
        mem_pend = 1'b0;
        model_reset();
        cycle();
        reset = 1'b0;
      end else begin
        if (!alu_pend)
          set_alu($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3) == 0);
        if (!mem_pend)
          set_mem($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3) == 0);
        cycle();
        alu_pend = bus.alu_valid && !g_alu;
        mem_pend = bus.mem_valid && !g_mem;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Schedules the single write port of the 32x32 register file between two writeback requesters: ALU result and memory-load result.
- Arbitrates round-robin on conflict and drops writes to register 0.
- Byte operations are done as a read-modify-write: the block reads the old value through a dedicated read address, merges the low byte, then writes the merged word.
- Sits between the writeback stage and the register file; it is the only driver of the register file's write enable, write register and write data inputs.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width.
- BYTE_W, 8, width of the byte merged on byte operations.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU write request.
- alu_ready  out  1  ALU request accepted this cycle when valid && ready.
- alu_reg  in  ADDR_W  destination register.
- alu_data  in  DATA_W  write data.
- alu_byte  in  1  byte operation: only the low BYTE_W bits are written.
- mem_valid, mem_ready, mem_reg, mem_data, mem_byte: same meaning, memory-load requester.
- rf_regWrite  out  1  register-file write strobe (registered).
- rf_write_reg  out  ADDR_W  register-file write index (registered).
- rf_write_data  out  DATA_W  register-file write data (registered).
- rf_rmw_reg  out  ADDR_W  read index used for byte read-modify-write (registered).
- rf_rmw_data  in  DATA_W  combinational read data for rf_rmw_reg.
- busy  out  1  high in RMW_READ and RMW_WRITE.
- wr_count  out  CNT_W  committed writes; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE.
  - rf_regWrite=0; rf_write_reg, rf_write_data, rf_rmw_reg = 0.
  - wr_count=0.
  - last_grant=MEM, so the ALU wins the first conflict.
  - Captured request registers cleared.
  - Reset mid-RMW abandons the operation; no write is issued.
- States: IDLE, RMW_READ, RMW_WRITE.
- Ready signals:
  - alu_ready=1 only in IDLE when granted; mem_ready likewise. Both are combinational from state, the valids and last_grant.
  - Grant in IDLE: only one valid means that one is granted. Both valid means the requester other than last_grant is granted.
  - last_grant updates on each accept.
  - Never both readies high. A non-granted valid stays pending; the requester holds its inputs.
- Word accept (byte=0) in cycle N:
  - If reg!=0: in cycle N+1 rf_regWrite=1 with rf_write_reg/rf_write_data = captured values.
  - If reg==0: no strobe; the request is accepted and dropped.
  - State stays IDLE, so back-to-back word writes run at one per cycle.
  - rf_regWrite deasserts the cycle after unless another accept occurred.
- Byte accept (byte=1) in cycle N:
  - reg==0: accepted and dropped, state stays IDLE.
  - Otherwise: N+1 RMW_READ, rf_rmw_reg=reg, rf_regWrite=0. rf_rmw_data is sampled at the end of N+1.
  - N+2 RMW_WRITE: rf_regWrite=1, data = {old[DATA_W-1:BYTE_W], new[BYTE_W-1:0]}.
  - N+3 IDLE.
  - No accepts occur in RMW_READ or RMW_WRITE.
- Hazard: the RMW_READ cycle never carries a write strobe, and any prior write committed at the edge entering it. No bypass logic is needed.
- wr_count increments by 1 on each cycle with rf_regWrite=1 and holds at 2^CNT_W-1 once saturated.

Test Plan:
- Reset mid-operation: assert reset during RMW_READ -> all outputs 0, state IDLE, no strobe follows; first post-reset conflict grants the ALU.
- Single ALU word: alu_valid=1, reg=3, data=0xDEADBEEF at cycle N -> alu_ready=1 at N; at N+1 rf_regWrite=1, rf_write_reg=3, data=0xDEADBEEF; wr_count=1.
- Conflict: both valid for 4 cycles (alu reg=1, mem reg=2, word) after reset -> grants alternate ALU, MEM, ALU, MEM; write strobes on 4 consecutive cycles; wr_count=4.
- Byte RMW: reg 5 holds 0x12345678; mem_valid, byte=1, reg=5, data=0x000000AB at N -> N+1 rf_rmw_reg=5, busy=1; N+2 write 0x123456AB to reg 5; mem_ready and alu_ready=0 during N+1..N+2.
- Register 0: word and byte requests to reg 0 -> accepted with ready=1, rf_regWrite never asserted, wr_count unchanged.
- Saturation: CNT_W=2, issue 5 word writes -> wr_count sequence 1,2,3,3,3.
